// File: rtl/pmp_check_arbiter.sv
// Shares one combinational PMP checker among NUM_REQ requesters.
// A round-robin grant captures one request into local registers, the shared
// checker is driven from those registers, and the sampled allow is returned
// to the owning requester over a valid/ready response channel.

package riscv;
    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;
endpackage

module pmp_check_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PLEN    = 34,
    parameter int unsigned ID_W    = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0][PLEN-1:0]        req_addr_i,
    input  riscv::pmp_access_t [NUM_REQ-1:0]    req_access_i,
    input  riscv::priv_lvl_t [NUM_REQ-1:0]      req_priv_i,
    input  logic [NUM_REQ-1:0][ID_W-1:0]        req_id_i,
    output logic [PLEN-1:0]                     pmp_addr_o,
    output riscv::pmp_access_t                  pmp_access_o,
    output riscv::priv_lvl_t                    pmp_priv_o,
    input  logic                                pmp_allow_i,
    input  logic                                cfg_busy_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    input  logic [NUM_REQ-1:0]                  rsp_ready_i,
    output logic                                rsp_allow_o,
    output logic [ID_W-1:0]                     rsp_id_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t             state_q, state_d;
    idx_t               ptr_q;
    idx_t               owner_q;
    idx_t               win;
    logic               any_valid;
    logic               rsp_hs;
    logic               grant;
    int unsigned        cand;

    logic [PLEN-1:0]    addr_q;
    riscv::pmp_access_t access_q;
    riscv::priv_lvl_t   priv_q;
    logic [ID_W-1:0]    id_q;
    logic               allow_q;

    // Round-robin search: first valid requester after the pointer, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        win       = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!any_valid && req_valid_i[idx_t'(cand)]) begin
                any_valid = 1'b1;
                win       = idx_t'(cand);
            end
        end
    end

    // A response completes only when its owner is ready; other readies are ignored.
    assign rsp_hs = (state_q == RESP) && rsp_ready_i[owner_q];

    // Grants happen from IDLE or chained onto a completing response, never
    // while the PMP configuration is being rewritten.
    assign grant = any_valid && !cfg_busy_i && ((state_q == IDLE) || rsp_hs);

    // Next state plus one-hot grant and response strobes.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (grant) begin
            req_ready_o[win] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
        case (state_q)
            IDLE:    if (grant) state_d = CHECK;
            CHECK:   if (!cfg_busy_i) state_d = RESP;
            RESP:    if (rsp_hs) state_d = grant ? CHECK : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request and result registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from values sampled at the same clock edge.
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= idx_t'(NUM_REQ - 1);
            owner_q  <= '0;
            addr_q   <= '0;
            access_q <= riscv::ACCESS_NONE;
            priv_q   <= riscv::PRIV_LVL_M;
            id_q     <= '0;
            allow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ptr_q    <= win;
                owner_q  <= win;
                addr_q   <= req_addr_i[win];
                access_q <= req_access_i[win];
                priv_q   <= req_priv_i[win];
                id_q     <= req_id_i[win];
            end
            if ((state_q == CHECK) && !cfg_busy_i) begin
                allow_q <= pmp_allow_i;
            end
        end
    end

    assign pmp_addr_o   = addr_q;
    assign pmp_access_o = access_q;
    assign pmp_priv_o   = priv_q;
    assign rsp_allow_o  = allow_q;
    assign rsp_id_o     = id_q;

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Self-checking bench for pmp_check_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.

module tb_pmp_check_arbiter;

    localparam int NUM_REQ = 3;
    localparam int PLEN    = 34;
    localparam int ID_W    = 4;

    logic                             clk = 1'b0;
    logic                             rst_i = 1'b1;
    logic [NUM_REQ-1:0]               req_valid_i;
    logic [NUM_REQ-1:0]               req_ready_o;
    logic [NUM_REQ-1:0][PLEN-1:0]     req_addr_i;
    riscv::pmp_access_t [NUM_REQ-1:0] req_access_i;
    riscv::priv_lvl_t [NUM_REQ-1:0]   req_priv_i;
    logic [NUM_REQ-1:0][ID_W-1:0]     req_id_i;
    logic [PLEN-1:0]                  pmp_addr_o;
    riscv::pmp_access_t               pmp_access_o;
    riscv::priv_lvl_t                 pmp_priv_o;
    logic                             pmp_allow_i;
    logic                             cfg_busy_i;
    logic [NUM_REQ-1:0]               rsp_valid_o;
    logic [NUM_REQ-1:0]               rsp_ready_i;
    logic                             rsp_allow_o;
    logic [ID_W-1:0]                  rsp_id_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    pmp_check_arbiter #(.NUM_REQ(NUM_REQ), .PLEN(PLEN), .ID_W(ID_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_access_i (req_access_i),
        .req_priv_i   (req_priv_i),
        .req_id_i     (req_id_i),
        .pmp_addr_o   (pmp_addr_o),
        .pmp_access_o (pmp_access_o),
        .pmp_priv_o   (pmp_priv_o),
        .pmp_allow_i  (pmp_allow_i),
        .cfg_busy_i   (cfg_busy_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_allow_o  (rsp_allow_o),
        .rsp_id_o     (rsp_id_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in PMP: upper half of the 32-bit space allowed, except user-mode
    // execute; output is garbage (0) while the configuration is being written.
    function automatic logic pmp_rule(logic [PLEN-1:0] a, riscv::pmp_access_t acc,
                                      riscv::priv_lvl_t p);
        return a[31] && !(p == riscv::PRIV_LVL_U && acc == riscv::ACCESS_EXEC);
    endfunction

    assign pmp_allow_i = cfg_busy_i ? 1'b0 : pmp_rule(pmp_addr_o, pmp_access_o, pmp_priv_o);

    function automatic logic [NUM_REQ-1:0] onehot(int i);
        logic [NUM_REQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit                 m_on   = 1'b0;
    bit                 m_out  = 1'b0;   // a transaction is outstanding
    bit                 m_resp = 1'b0;   // its result is known and being offered
    int                 m_owner = 0;
    int                 m_ptr   = NUM_REQ - 1;
    logic [PLEN-1:0]    m_addr;
    riscv::pmp_access_t m_acc;
    riscv::priv_lvl_t   m_priv;
    logic [ID_W-1:0]    m_id;
    bit                 m_allow;

    int grant_q[$];
    int grant_cyc[$];
    int hs_cyc[$];

    // Compare against the model, then advance it past the coming clock edge.
    always @(negedge clk) begin : model
        logic [NUM_REQ-1:0] e_ready, e_valid;
        bit hs, elig, found;
        int w, c;
        hs = 1'b0; elig = 1'b0; found = 1'b0; w = 0; c = 0;
        if (m_on) begin
            e_valid = m_resp ? onehot(m_owner) : '0;
            hs      = m_resp && rsp_ready_i[m_owner];
            elig    = !cfg_busy_i && (!m_out || hs);
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (m_ptr + k) % NUM_REQ;
                if (!found && req_valid_i[c]) begin
                    found = 1'b1;
                    w     = c;
                end
            end
            e_ready = (elig && found) ? onehot(w) : '0;
            check("m_req_ready", 64'(req_ready_o), 64'(e_ready));
            check("m_rsp_valid", 64'(rsp_valid_o), 64'(e_valid));
            check("m_pmp_addr", 64'(pmp_addr_o), 64'(m_addr));
            check("m_pmp_access", 64'(pmp_access_o), 64'(m_acc));
            check("m_pmp_priv", 64'(pmp_priv_o), 64'(m_priv));
            if (m_resp) begin
                check("m_rsp_allow", 64'(rsp_allow_o), 64'(m_allow));
                check("m_rsp_id", 64'(rsp_id_o), 64'(m_id));
            end
            if (req_ready_o != '0) begin
                for (int k = 0; k < NUM_REQ; k++)
                    if (req_ready_o[k]) grant_q.push_back(k);
                grant_cyc.push_back(cyc);
            end
            if ((rsp_valid_o & rsp_ready_i) != '0) hs_cyc.push_back(cyc);
        end
        if (rst_i) begin
            m_on = 1'b1; m_out = 1'b0; m_resp = 1'b0; m_owner = 0;
            m_ptr = NUM_REQ - 1; m_addr = '0; m_acc = riscv::ACCESS_NONE;
            m_priv = riscv::PRIV_LVL_M; m_id = '0; m_allow = 1'b0;
        end else if (m_on) begin
            if (m_out && !m_resp && !cfg_busy_i) begin
                m_resp  = 1'b1;
                m_allow = pmp_rule(m_addr, m_acc, m_priv);
            end else if (hs) begin
                m_out  = 1'b0;
                m_resp = 1'b0;
            end
            if (elig && found) begin
                m_out = 1'b1; m_resp = 1'b0; m_ptr = w; m_owner = w;
                m_addr = req_addr_i[w]; m_acc = req_access_i[w];
                m_priv = req_priv_i[w]; m_id = req_id_i[w];
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_i       = 1'b1;
        req_valid_i = '0;
        cfg_busy_i  = 1'b0;
        rsp_ready_i = '1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic set_req(int i, logic [PLEN-1:0] a, riscv::pmp_access_t acc,
                           riscv::priv_lvl_t p, logic [ID_W-1:0] id);
        req_addr_i[i]   = a;
        req_access_i[i] = acc;
        req_priv_i[i]   = p;
        req_id_i[i]     = id;
    endtask

    initial begin
        req_valid_i = '0;
        rsp_ready_i = '1;
        cfg_busy_i  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, '0, riscv::ACCESS_NONE, riscv::PRIV_LVL_M, '0);

        // Reset values
        reset_dut();
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready_o), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check("rst_rsp_allow", 64'(rsp_allow_o), 64'h0);
        check("rst_rsp_id", 64'(rsp_id_o), 64'h0);
        check("rst_pmp_addr", 64'(pmp_addr_o), 64'h0);
        check("rst_pmp_access", 64'(pmp_access_o), 64'h0);
        check("rst_pmp_priv", 64'(pmp_priv_o), 64'h3);

        // Single request from requester 1
        tick();
        set_req(1, 34'h0_8000_0000, riscv::ACCESS_READ, riscv::PRIV_LVL_U, 4'd5);
        req_valid_i = 3'b010;
        @(negedge clk);
        check("t1_grant", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = '0;
        @(negedge clk);
        check("t1_pmp_addr", 64'(pmp_addr_o), 64'h8000_0000);
        check("t1_no_rsp_yet", 64'(rsp_valid_o), 64'h0);
        tick();
        @(negedge clk);
        check("t1_rsp_valid", 64'(rsp_valid_o), 64'h2);
        check("t1_rsp_allow", 64'(rsp_allow_o), 64'h1);
        check("t1_rsp_id", 64'(rsp_id_o), 64'h5);
        tick();
        @(negedge clk);
        check("t1_rsp_done", 64'(rsp_valid_o), 64'h0);

        // Round-robin fairness, back-to-back
        reset_dut();
        grant_q.delete(); grant_cyc.delete(); hs_cyc.delete();
        set_req(0, 34'h0_8000_0100, riscv::ACCESS_READ,  riscv::PRIV_LVL_M, 4'd1);
        set_req(1, 34'h0_0000_0200, riscv::ACCESS_WRITE, riscv::PRIV_LVL_S, 4'd2);
        set_req(2, 34'h0_8000_0300, riscv::ACCESS_EXEC,  riscv::PRIV_LVL_U, 4'd3);
        req_valid_i = 3'b111;
        repeat (12) tick();
        req_valid_i = '0;
        repeat (4) tick();
        check("rr_grant_count", 64'(grant_q.size()), 64'd6);
        check("rr_rsp_count", 64'(hs_cyc.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++)
            check("rr_order", 64'(grant_q[i]), 64'(i % 3));
        for (int i = 1; i < grant_cyc.size(); i++)
            check("rr_grant_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd2);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("rr_rsp_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);

        // Response backpressure on requester 0
        reset_dut();
        set_req(0, 34'h0_8000_1000, riscv::ACCESS_WRITE, riscv::PRIV_LVL_S, 4'd3);
        set_req(1, 34'h0_0000_2000, riscv::ACCESS_EXEC,  riscv::PRIV_LVL_M, 4'd7);
        rsp_ready_i = 3'b110;
        req_valid_i = 3'b011;
        @(negedge clk);
        check("bp_grant0", 64'(req_ready_o), 64'h1);
        tick();
        @(negedge clk);
        check("bp_check", 64'(rsp_valid_o), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("bp_hold_valid", 64'(rsp_valid_o), 64'h1);
            check("bp_hold_noready", 64'(req_ready_o), 64'h0);
            check("bp_hold_id", 64'(rsp_id_o), 64'h3);
            check("bp_hold_allow", 64'(rsp_allow_o), 64'h1);
        end
        tick();
        rsp_ready_i = 3'b111;
        @(negedge clk);
        check("bp_chain_grant1", 64'(req_ready_o), 64'h2);
        check("bp_chain_valid", 64'(rsp_valid_o), 64'h1);
        tick();
        req_valid_i = '0;
        @(negedge clk);
        check("bp_req1_pmp_addr", 64'(pmp_addr_o), 64'h2000);
        tick();
        @(negedge clk);
        check("bp_req1_rsp", 64'(rsp_valid_o), 64'h2);
        check("bp_req1_allow", 64'(rsp_allow_o), 64'h0);
        check("bp_req1_id", 64'(rsp_id_o), 64'h7);
        tick();

        // Configuration hold in CHECK, then busy in RESP and IDLE
        reset_dut();
        set_req(2, 34'h0_8000_0000, riscv::ACCESS_READ, riscv::PRIV_LVL_M, 4'd9);
        set_req(0, 34'h0_8000_0400, riscv::ACCESS_READ, riscv::PRIV_LVL_U, 4'd4);
        req_valid_i = 3'b100;
        @(negedge clk);
        check("cfg_grant2", 64'(req_ready_o), 64'h4);
        tick();
        req_valid_i = '0;
        cfg_busy_i  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("cfg_busy_no_rsp", 64'(rsp_valid_o), 64'h0);
            if (k < 2) tick();
        end
        tick();
        cfg_busy_i = 1'b0;
        @(negedge clk);
        check("cfg_sample_no_rsp", 64'(rsp_valid_o), 64'h0);
        tick();
        cfg_busy_i  = 1'b1;
        req_valid_i = 3'b001;
        @(negedge clk);
        check("cfg_rsp_valid", 64'(rsp_valid_o), 64'h4);
        check("cfg_rsp_allow", 64'(rsp_allow_o), 64'h1);
        check("cfg_rsp_id", 64'(rsp_id_o), 64'h9);
        check("cfg_resp_no_chain", 64'(req_ready_o), 64'h0);
        tick();
        @(negedge clk);
        check("cfg_idle_blocked", 64'(req_ready_o), 64'h0);
        check("cfg_idle_no_rsp", 64'(rsp_valid_o), 64'h0);
        tick();
        cfg_busy_i = 1'b0;
        @(negedge clk);
        check("cfg_idle_grant0", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = '0;
        repeat (3) tick();

        // Reset while requester 2 holds a pending response
        reset_dut();
        set_req(2, 34'h0_8000_0500, riscv::ACCESS_READ, riscv::PRIV_LVL_S, 4'd11);
        rsp_ready_i = 3'b011;
        req_valid_i = 3'b100;
        @(negedge clk);
        check("rr_rst_grant2", 64'(req_ready_o), 64'h4);
        tick();
        req_valid_i = '0;
        tick();
        @(negedge clk);
        check("rr_rst_pending", 64'(rsp_valid_o), 64'h4);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check("post_rst_req_ready", 64'(req_ready_o), 64'h0);
        check("post_rst_pmp_addr", 64'(pmp_addr_o), 64'h0);
        check("post_rst_pmp_priv", 64'(pmp_priv_o), 64'h3);
        check("post_rst_rsp_id", 64'(rsp_id_o), 64'h0);
        check("post_rst_rsp_allow", 64'(rsp_allow_o), 64'h0);
        tick();
        req_valid_i = 3'b111;
        rsp_ready_i = 3'b111;
        @(negedge clk);
        check("post_rst_first_grant", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = '0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
